exc_unit: RTL and testbench
===========================

# exc_unit

Exception and interrupt controller for the Ultiparc CPU. It sits directly upstream of `coproc0`. It collects synchronous exception requests from the IF/ID/EX/MEM pipeline stages and the external interrupt lines, picks the single highest-priority event, and hands it to `coproc0` (cause code, EPC, BD, BadVAddr) over a valid/ack handshake. It then flushes the pipeline and redirects fetch to the exception vector, or to EPC on ERET.

## Interface
Parameters:
- `NIRQ`, 6, number of hardware interrupt lines.
- `EXC_VEC`, 32'h0000_0080, general exception vector.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_irq` in NIRQ: level interrupt requests.
- `i_ie` in 1, `i_im` in NIRQ: Status.IE and Status.IM from `coproc0`.
- `i_epc` in 32: current EPC from `coproc0`.
- `i_if_valid`, `i_if_bd`, `i_if_aderr` in 1, `i_if_pc` in 32: IF stage status, delay-slot flag, fetch address error, PC.
- `i_id_valid`, `i_id_bd`, `i_id_ri`, `i_id_sys`, `i_id_bp` in 1, `i_id_pc` in 32: ID stage status, reserved instruction, syscall, break, PC.
- `i_ex_valid`, `i_ex_bd`, `i_ex_ov` in 1, `i_ex_pc` in 32: EX stage status, overflow, PC.
- `i_mem_valid`, `i_mem_bd`, `i_mem_adel`, `i_mem_ades`, `i_mem_eret` in 1, `i_mem_pc`, `i_mem_addr` in 32: MEM stage status, load/store address errors, ERET, PC, data address.
- `o_exc_valid` out 1: exception record valid to `coproc0`.
- `i_exc_ack` in 1: `coproc0` has latched the record.
- `o_exc_code` out 5, `o_exc_epc` out 32, `o_exc_bd` out 1: Cause.ExcCode, EPC value, Cause.BD.
- `o_exc_bva` out 32, `o_exc_bva_we` out 1: BadVAddr value and write enable.
- `o_ip` out NIRQ: registered `i_irq`, fed to Cause.IP.
- `o_rfe` out 1: one-cycle pulse telling `coproc0` to restore Status on ERET.
- `o_flush` out 1: kill all IF–MEM stages.
- `o_redirect` out 1, `o_redirect_pc` out 32: one-cycle fetch redirect.

## Operation
- `o_ip` is `i_irq` registered once per cycle. An interrupt is pending when `i_ie & |(o_ip & i_im)`.
- Priority, highest first (only stages with `valid`=1 count):
  - MEM AdEL (4, bva=mem_addr), then MEM AdES (5, bva=mem_addr).
  - EX Ov (12).
  - ID RI (10), then Sys (8), then Bp (9).
  - IF AdEL (4, bva=if_pc).
  - Interrupt (0), only if `i_mem_valid`; attributed to the MEM instruction, which does not commit.
- EPC = stage PC, or PC−4 (modulo 2^32) when that stage's BD=1. `o_exc_bd` = that stage's BD. `o_exc_bva_we`=1 only for AdEL/AdES.
- FSM states:
  - IDLE: on any event, capture the record and go to WAIT_ACK. Otherwise, on `i_mem_eret`, go to REDIRECT with target `i_epc` and pulse `o_rfe`. An exception always wins over ERET in the same cycle.
  - WAIT_ACK: `o_exc_valid`=1 and `o_flush`=1. Record is held stable and all new requests are ignored. On `i_exc_ack`, go to REDIRECT with target `EXC_VEC`.
  - REDIRECT: `o_redirect`=1 and `o_flush`=1 for exactly one cycle, then IDLE.
- Reset in any state returns to IDLE and discards the captured record.

## Timing
- Reset values: all outputs 0, `o_redirect_pc`=0, state IDLE.
- Exception requests sampled in cycle N give `o_exc_valid`/`o_flush` high from cycle N+1.
- `i_exc_ack` sampled high in cycle M gives `o_exc_valid`=0 and `o_redirect`=1 in M+1, and IDLE in M+2.
- `i_exc_ack` is ignored outside WAIT_ACK. With ack tied high, the minimum exception sequence is 3 cycles: WAIT_ACK, REDIRECT, IDLE.
- ERET sampled in cycle N gives `o_rfe`, `o_redirect` and `o_flush` high in N+1.
- `i_irq` to `o_ip` latency is 1 cycle, so interrupt recognition is 1 cycle after `i_irq` rises.

## Test plan
- Reset: assert `rst` mid-WAIT_ACK → next cycle all outputs 0, IDLE; the old record never reappears.
- `i_ex_ov`, ex_pc=0x1000, bd=0, ack after 2 cycles → code 12, epc 0x1000, valid held 2 cycles, then redirect to 0x80 for one cycle.
- Simultaneous MEM AdES (addr 0x2003, pc 0x2000) and ID Sys → code 5, epc 0x2000, bva 0x2003, bva_we=1.
- ID RI with bd=1, pc 0x0 → epc 0xFFFF_FFFC (wrap), bd=1.
- `i_irq[2]`=1, im=0x04, ie=1, mem_pc 0x3000 → code 0 two cycles after irq rises, epc 0x3000. With ie=0 → no exception, but `o_ip`=0x04.
- ERET with i_epc 0x4000 → `o_rfe` and `o_redirect` with pc 0x4000, both for one cycle. ERET plus MEM AdEL in the same cycle → exception only, no `o_rfe`.

Source files
------------

// File: rtl/exc_unit.sv
// exc_unit -- exception and interrupt controller for the Ultiparc CPU.
//
// Gathers synchronous exception requests from the IF/ID/EX/MEM stages and the
// masked hardware interrupt lines. It selects the single highest-priority
// event and hands the record (cause code, EPC, BD, BadVAddr) to coproc0 over a
// valid/ack handshake. It then flushes the pipeline and redirects fetch to
// EXC_VEC. For ERET, it redirects to the EPC supplied by coproc0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_irq, i_ie, i_im        interrupt lines, Status.IE, Status.IM
//   i_epc                    current EPC (ERET target)
//   i_if_* / i_id_* /
//   i_ex_* / i_mem_*         per-stage valid, delay-slot flag, error flags, PC
//   i_exc_ack                coproc0 has latched the exception record
//   o_exc_valid, o_exc_code,
//   o_exc_epc, o_exc_bd,
//   o_exc_bva, o_exc_bva_we  exception record towards coproc0
//   o_ip                     registered i_irq (Cause.IP)
//   o_rfe                    restore-Status pulse on ERET
//   o_flush                  kill all IF..MEM stages
//   o_redirect, o_redirect_pc one-cycle fetch redirect
module exc_unit #(
  parameter int          NIRQ    = 6,
  parameter logic [31:0] EXC_VEC = 32'h0000_0080
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] i_irq,
  input  logic            i_ie,
  input  logic [NIRQ-1:0] i_im,
  input  logic [31:0]     i_epc,
  input  logic            i_if_valid,
  input  logic            i_if_bd,
  input  logic            i_if_aderr,
  input  logic [31:0]     i_if_pc,
  input  logic            i_id_valid,
  input  logic            i_id_bd,
  input  logic            i_id_ri,
  input  logic            i_id_sys,
  input  logic            i_id_bp,
  input  logic [31:0]     i_id_pc,
  input  logic            i_ex_valid,
  input  logic            i_ex_bd,
  input  logic            i_ex_ov,
  input  logic [31:0]     i_ex_pc,
  input  logic            i_mem_valid,
  input  logic            i_mem_bd,
  input  logic            i_mem_adel,
  input  logic            i_mem_ades,
  input  logic            i_mem_eret,
  input  logic [31:0]     i_mem_pc,
  input  logic [31:0]     i_mem_addr,
  output logic            o_exc_valid,
  input  logic            i_exc_ack,
  output logic [4:0]      o_exc_code,
  output logic [31:0]     o_exc_epc,
  output logic            o_exc_bd,
  output logic [31:0]     o_exc_bva,
  output logic            o_exc_bva_we,
  output logic [NIRQ-1:0] o_ip,
  output logic            o_rfe,
  output logic            o_flush,
  output logic            o_redirect,
  output logic [31:0]     o_redirect_pc
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic        irq_pend_s;
  logic        ev_s;
  logic [4:0]  code_s;
  logic [31:0] pc_s;
  logic        bd_s;
  logic [31:0] bva_s;
  logic        bva_we_s;
  logic [31:0] epc_s;
  logic        rfe_s;
  logic        rpc_load_s;
  logic [31:0] rpc_s;

  // Priority selection of the single event to report this cycle.
  always_comb begin
    irq_pend_s = i_ie & (|(o_ip & i_im));
    ev_s       = 1'b1;
    code_s     = 5'd0;
    pc_s       = 32'd0;
    bd_s       = 1'b0;
    bva_s      = 32'd0;
    bva_we_s   = 1'b0;
    if (i_mem_valid && i_mem_adel) begin
      code_s = 5'd4;  pc_s = i_mem_pc; bd_s = i_mem_bd;
      bva_s  = i_mem_addr; bva_we_s = 1'b1;
    end else if (i_mem_valid && i_mem_ades) begin
      code_s = 5'd5;  pc_s = i_mem_pc; bd_s = i_mem_bd;
      bva_s  = i_mem_addr; bva_we_s = 1'b1;
    end else if (i_ex_valid && i_ex_ov) begin
      code_s = 5'd12; pc_s = i_ex_pc; bd_s = i_ex_bd;
    end else if (i_id_valid && i_id_ri) begin
      code_s = 5'd10; pc_s = i_id_pc; bd_s = i_id_bd;
    end else if (i_id_valid && i_id_sys) begin
      code_s = 5'd8;  pc_s = i_id_pc; bd_s = i_id_bd;
    end else if (i_id_valid && i_id_bp) begin
      code_s = 5'd9;  pc_s = i_id_pc; bd_s = i_id_bd;
    end else if (i_if_valid && i_if_aderr) begin
      code_s = 5'd4;  pc_s = i_if_pc; bd_s = i_if_bd;
      bva_s  = i_if_pc; bva_we_s = 1'b1;
    end else if (i_mem_valid && irq_pend_s) begin
      // Interrupt is charged to the MEM instruction, which will not commit.
      code_s = 5'd0;  pc_s = i_mem_pc; bd_s = i_mem_bd;
    end else begin
      ev_s = 1'b0;
    end
  end

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign epc_s = bd_s ? (pc_s - 32'd4) : pc_s;

  // Next-state logic of the handshake/redirect sequencer.
  always_comb begin
    state_s    = state_r;
    rfe_s      = 1'b0;
    rpc_load_s = 1'b0;
    rpc_s      = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (ev_s) begin
          state_s = ST_WAIT_ACK;
        end else if (i_mem_eret) begin
          state_s    = ST_REDIRECT;
          rfe_s      = 1'b1;
          rpc_load_s = 1'b1;
          rpc_s      = i_epc;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (i_exc_ack) begin
          state_s    = ST_REDIRECT;
          rpc_load_s = 1'b1;
          rpc_s      = EXC_VEC;
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      ST_REDIRECT: state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // State, registered outputs and the captured exception record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      o_ip          <= '0;
      o_exc_valid   <= 1'b0;
      o_flush       <= 1'b0;
      o_redirect    <= 1'b0;
      o_rfe         <= 1'b0;
      o_redirect_pc <= 32'd0;
      o_exc_code    <= 5'd0;
      o_exc_epc     <= 32'd0;
      o_exc_bd      <= 1'b0;
      o_exc_bva     <= 32'd0;
      o_exc_bva_we  <= 1'b0;
    end else begin
      state_r     <= state_s;
      o_ip        <= i_irq;
      o_exc_valid <= (state_s == ST_WAIT_ACK);
      o_flush     <= (state_s != ST_IDLE);
      o_redirect  <= (state_s == ST_REDIRECT);
      o_rfe       <= rfe_s;
      if (rpc_load_s) begin
        o_redirect_pc <= rpc_s;
      end
      if ((state_r == ST_IDLE) && ev_s) begin
        o_exc_code   <= code_s;
        o_exc_epc    <= epc_s;
        o_exc_bd     <= bd_s;
        o_exc_bva    <= bva_s;
        o_exc_bva_we <= bva_we_s;
      end else if (state_s != ST_WAIT_ACK) begin
        // BadVAddr write enable is only meaningful while the record is offered.
        o_exc_bva_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exc_unit.sv
module tb_exc_unit;
  localparam int          NIRQ    = 6;
  localparam logic [31:0] EXC_VEC = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst;
  logic [NIRQ-1:0] i_irq, i_im;
  logic i_ie;
  logic [31:0] i_epc;
  logic i_if_valid, i_if_bd, i_if_aderr;
  logic [31:0] i_if_pc;
  logic i_id_valid, i_id_bd, i_id_ri, i_id_sys, i_id_bp;
  logic [31:0] i_id_pc;
  logic i_ex_valid, i_ex_bd, i_ex_ov;
  logic [31:0] i_ex_pc;
  logic i_mem_valid, i_mem_bd, i_mem_adel, i_mem_ades, i_mem_eret;
  logic [31:0] i_mem_pc, i_mem_addr;
  logic i_exc_ack;
  logic o_exc_valid, o_exc_bd, o_exc_bva_we, o_rfe, o_flush, o_redirect;
  logic [4:0] o_exc_code;
  logic [31:0] o_exc_epc, o_exc_bva, o_redirect_pc;
  logic [NIRQ-1:0] o_ip;

  exc_unit #(.NIRQ(NIRQ), .EXC_VEC(EXC_VEC)) dut (
    .clk(clk), .rst(rst), .i_irq(i_irq), .i_ie(i_ie), .i_im(i_im), .i_epc(i_epc),
    .i_if_valid(i_if_valid), .i_if_bd(i_if_bd), .i_if_aderr(i_if_aderr), .i_if_pc(i_if_pc),
    .i_id_valid(i_id_valid), .i_id_bd(i_id_bd), .i_id_ri(i_id_ri), .i_id_sys(i_id_sys),
    .i_id_bp(i_id_bp), .i_id_pc(i_id_pc),
    .i_ex_valid(i_ex_valid), .i_ex_bd(i_ex_bd), .i_ex_ov(i_ex_ov), .i_ex_pc(i_ex_pc),
    .i_mem_valid(i_mem_valid), .i_mem_bd(i_mem_bd), .i_mem_adel(i_mem_adel),
    .i_mem_ades(i_mem_ades), .i_mem_eret(i_mem_eret), .i_mem_pc(i_mem_pc),
    .i_mem_addr(i_mem_addr),
    .o_exc_valid(o_exc_valid), .i_exc_ack(i_exc_ack), .o_exc_code(o_exc_code),
    .o_exc_epc(o_exc_epc), .o_exc_bd(o_exc_bd), .o_exc_bva(o_exc_bva),
    .o_exc_bva_we(o_exc_bva_we), .o_ip(o_ip), .o_rfe(o_rfe), .o_flush(o_flush),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a record is either being offered (m_hold), or a redirect
  // is in progress (m_redir), or neither.
  logic [NIRQ-1:0] m_ip;
  logic        m_hold, m_redir, m_rfe, m_bvawe, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bva, m_rpc;

  task automatic model_update();
    logic        c[8];
    logic [4:0]  cd[8];
    logic [31:0] pc[8];
    logic        b[8];
    logic [31:0] va[8];
    logic        we[8];
    logic        pend, found;
    int          k;
    pend = i_ie && ((m_ip & i_im) != '0);
    c[0] = i_mem_valid && i_mem_adel; cd[0] = 5'd4;  pc[0] = i_mem_pc; b[0] = i_mem_bd; va[0] = i_mem_addr; we[0] = 1'b1;
    c[1] = i_mem_valid && i_mem_ades; cd[1] = 5'd5;  pc[1] = i_mem_pc; b[1] = i_mem_bd; va[1] = i_mem_addr; we[1] = 1'b1;
    c[2] = i_ex_valid && i_ex_ov;     cd[2] = 5'd12; pc[2] = i_ex_pc;  b[2] = i_ex_bd;  va[2] = 32'd0;      we[2] = 1'b0;
    c[3] = i_id_valid && i_id_ri;     cd[3] = 5'd10; pc[3] = i_id_pc;  b[3] = i_id_bd;  va[3] = 32'd0;      we[3] = 1'b0;
    c[4] = i_id_valid && i_id_sys;    cd[4] = 5'd8;  pc[4] = i_id_pc;  b[4] = i_id_bd;  va[4] = 32'd0;      we[4] = 1'b0;
    c[5] = i_id_valid && i_id_bp;     cd[5] = 5'd9;  pc[5] = i_id_pc;  b[5] = i_id_bd;  va[5] = 32'd0;      we[5] = 1'b0;
    c[6] = i_if_valid && i_if_aderr;  cd[6] = 5'd4;  pc[6] = i_if_pc;  b[6] = i_if_bd;  va[6] = i_if_pc;    we[6] = 1'b1;
    c[7] = i_mem_valid && pend;       cd[7] = 5'd0;  pc[7] = i_mem_pc; b[7] = i_mem_bd; va[7] = 32'd0;      we[7] = 1'b0;
    found = 1'b0;
    k = 0;
    for (int j = 7; j >= 0; j--) if (c[j]) begin found = 1'b1; k = j; end
    m_rfe = 1'b0;
    if (rst) begin
      m_hold = 0; m_redir = 0; m_bvawe = 0; m_code = 0; m_epc = 0; m_bd = 0; m_bva = 0; m_rpc = 0;
      m_ip = '0;
      return;
    end
    if (m_hold) begin
      if (i_exc_ack) begin m_hold = 0; m_redir = 1; m_rpc = EXC_VEC; m_bvawe = 0; end
    end else if (m_redir) begin
      m_redir = 0;
    end else if (found) begin
      m_hold = 1; m_code = cd[k]; m_bd = b[k]; m_bva = va[k]; m_bvawe = we[k];
      m_epc = b[k] ? pc[k] - 32'd4 : pc[k];
    end else if (i_mem_eret) begin
      m_redir = 1; m_rfe = 1; m_rpc = i_epc;
    end
    m_ip = i_irq;
  endtask

  task automatic compare_all();
    chk("valid", o_exc_valid, m_hold);
    chk("flush", o_flush, m_hold | m_redir);
    chk("redirect", o_redirect, m_redir);
    chk("rfe", o_rfe, m_rfe);
    chk("ip", o_ip, m_ip);
    chk("bva_we", o_exc_bva_we, m_hold & m_bvawe);
    if (m_hold) begin
      chk("code", o_exc_code, m_code);
      chk("epc", o_exc_epc, m_epc);
      chk("bd", o_exc_bd, m_bd);
      chk("bva", o_exc_bva, m_bva);
    end
    if (m_redir) chk("redirect_pc", o_redirect_pc, m_rpc);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic clr();
    rst = 0; i_irq = '0; i_ie = 0; i_im = '0; i_epc = 0; i_exc_ack = 0;
    i_if_valid = 0; i_if_bd = 0; i_if_aderr = 0; i_if_pc = 0;
    i_id_valid = 0; i_id_bd = 0; i_id_ri = 0; i_id_sys = 0; i_id_bp = 0; i_id_pc = 0;
    i_ex_valid = 0; i_ex_bd = 0; i_ex_ov = 0; i_ex_pc = 0;
    i_mem_valid = 0; i_mem_bd = 0; i_mem_adel = 0; i_mem_ades = 0; i_mem_eret = 0;
    i_mem_pc = 0; i_mem_addr = 0;
  endtask

  task automatic finish_exc();
    clr(); i_exc_ack = 1; step();
    clr(); step();
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] v;
    v = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
    return v;
  endfunction

  initial begin
    clr();
    rst = 1; step();
    chk("rst_valid", o_exc_valid, 1'b0); chk("rst_code", o_exc_code, 5'd0);
    chk("rst_epc", o_exc_epc, 32'd0); chk("rst_rpc", o_redirect_pc, 32'd0);
    chk("rst_flush", o_flush, 1'b0);
    rst = 0; step();

    // Overflow, ack after two cycles of valid.
    i_ex_valid = 1; i_ex_ov = 1; i_ex_pc = 32'h1000; step();
    chk("ov_code", o_exc_code, 5'd12); chk("ov_epc", o_exc_epc, 32'h1000);
    chk("ov_valid1", o_exc_valid, 1'b1);
    clr(); step(); chk("ov_valid2", o_exc_valid, 1'b1);
    i_exc_ack = 1; step();
    chk("ov_redir", o_redirect, 1'b1); chk("ov_rpc", o_redirect_pc, 32'h80);
    chk("ov_valid3", o_exc_valid, 1'b0);
    clr(); step(); chk("ov_redir_end", o_redirect, 1'b0); chk("ov_flush_end", o_flush, 1'b0);

    // Reset in the middle of WAIT_ACK.
    i_ex_valid = 1; i_ex_ov = 1; i_ex_pc = 32'h5555; step();
    clr(); rst = 1; step();
    chk("mrst_valid", o_exc_valid, 1'b0); chk("mrst_epc", o_exc_epc, 32'd0);
    rst = 0; step(); step();
    chk("mrst_stale", o_exc_valid, 1'b0); chk("mrst_code", o_exc_code, 5'd0);

    // MEM AdES beats ID Sys.
    i_mem_valid = 1; i_mem_ades = 1; i_mem_addr = 32'h2003; i_mem_pc = 32'h2000;
    i_id_valid = 1; i_id_sys = 1; i_id_pc = 32'h2004; step();
    chk("ades_code", o_exc_code, 5'd5); chk("ades_epc", o_exc_epc, 32'h2000);
    chk("ades_bva", o_exc_bva, 32'h2003); chk("ades_we", o_exc_bva_we, 1'b1);
    finish_exc();

    // RI in a delay slot at PC 0 wraps.
    i_id_valid = 1; i_id_ri = 1; i_id_bd = 1; i_id_pc = 32'h0; step();
    chk("ri_epc", o_exc_epc, 32'hFFFF_FFFC); chk("ri_bd", o_exc_bd, 1'b1);
    chk("ri_code", o_exc_code, 5'd10);
    finish_exc();

    // Interrupt, recognised two cycles after the line rises.
    i_im = 6'h04; i_ie = 1; i_mem_valid = 1; i_mem_pc = 32'h3000; i_irq = 6'h04; step();
    chk("irq_early", o_exc_valid, 1'b0);
    step();
    chk("irq_valid", o_exc_valid, 1'b1); chk("irq_code", o_exc_code, 5'd0);
    chk("irq_epc", o_exc_epc, 32'h3000);
    finish_exc();
    i_im = 6'h04; i_ie = 0; i_mem_valid = 1; i_mem_pc = 32'h3000; i_irq = 6'h04; step(); step();
    chk("irq_masked", o_exc_valid, 1'b0); chk("irq_ip", o_ip, 6'h04);
    clr(); step();

    // ERET alone, then ERET racing a MEM AdEL.
    i_mem_valid = 1; i_mem_eret = 1; i_epc = 32'h4000; step();
    chk("eret_rfe", o_rfe, 1'b1); chk("eret_redir", o_redirect, 1'b1);
    chk("eret_pc", o_redirect_pc, 32'h4000);
    clr(); step(); chk("eret_rfe_end", o_rfe, 1'b0); chk("eret_redir_end", o_redirect, 1'b0);
    i_mem_valid = 1; i_mem_eret = 1; i_epc = 32'h4000; i_mem_adel = 1;
    i_mem_addr = 32'h4001; i_mem_pc = 32'h5000; step();
    chk("race_valid", o_exc_valid, 1'b1); chk("race_rfe", o_rfe, 1'b0);
    chk("race_code", o_exc_code, 5'd4);
    finish_exc();

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      i_irq = NIRQ'($urandom); i_im = NIRQ'($urandom); i_ie = 1'($urandom);
      i_epc = $urandom; i_exc_ack = 1'($urandom);
      i_if_valid = 1'($urandom); i_if_bd = 1'($urandom);
      i_if_aderr = ($urandom_range(0, 7) == 0); i_if_pc = rnd_pc();
      i_id_valid = 1'($urandom); i_id_bd = 1'($urandom);
      i_id_ri = ($urandom_range(0, 7) == 0); i_id_sys = ($urandom_range(0, 7) == 0);
      i_id_bp = ($urandom_range(0, 7) == 0); i_id_pc = rnd_pc();
      i_ex_valid = 1'($urandom); i_ex_bd = 1'($urandom);
      i_ex_ov = ($urandom_range(0, 7) == 0); i_ex_pc = rnd_pc();
      i_mem_valid = 1'($urandom); i_mem_bd = 1'($urandom);
      i_mem_adel = ($urandom_range(0, 9) == 0); i_mem_ades = ($urandom_range(0, 9) == 0);
      i_mem_eret = ($urandom_range(0, 5) == 0); i_mem_pc = rnd_pc(); i_mem_addr = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
